// File: rtl/fwd_hazard_if.sv
// Decode-side bundle between the ID stage and the forwarding/hazard controller.
//   master : decode stage (drives ID instruction fields, consumes controls)
//   slave  : fwd_hazard_ctrl (consumes ID fields, drives selects/stall/busy)
// Signals:
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
//   id_is_load, id_is_md, id_uses_hilo       : ID instruction description
//   fwd_a_sel, fwd_b_sel                      : EX operand mux selects
//   stall, bubble_ex, md_busy                 : pipeline control
interface fwd_hazard_if #(
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_addr;
    logic              id_is_load;
    logic              id_is_md;
    logic              id_uses_hilo;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic              bubble_ex;
    logic              md_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
               id_wr_addr, id_is_load, id_is_md, id_uses_hilo,
        input  fwd_a_sel, fwd_b_sel, stall, bubble_ex, md_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
               id_wr_addr, id_is_load, id_is_md, id_uses_hilo,
        output fwd_a_sel, fwd_b_sel, stall, bubble_ex, md_busy
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and hazard/stall controller for the 5-stage pipe.
// Tracks a shadow copy of the EX/MEM/WB destination state so it needs no
// datapath inputs.
// Ports:
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : fwd_hazard_if slave (ID fields in; selects, stall,
//                bubble_ex, md_busy out)
// Select encoding: 00 regfile, 01 WB result, 10 MEM ALU result,
// 11 MEM load data (never driven).
module fwd_hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 8,
    parameter int unsigned REG_AW    = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_addr;
        logic              is_load;
    } dst_rec_t;

    typedef struct packed {
        dst_rec_t          dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } ex_rec_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    ex_rec_t    ex_q;
    ex_rec_t    ex_d;
    dst_rec_t   mem_q;
    dst_rec_t   wb_q;
    md_state_t  md_state;
    logic [CNT_W-1:0] md_cnt;

    logic       load_use_c;
    logic       md_hazard_c;
    logic       stall_c;
    logic       md_busy_c;
    logic [1:0] sel_a_c;
    logic [1:0] sel_b_c;

    // WB never holds a load that matters for forwarding; kept for record symmetry.
    logic unused_wb_is_load;
    assign unused_wb_is_load = wb_q.is_load;

    assign md_busy_c = (md_state == MD_BUSY);

    // Hazard detection against the instruction currently in ID.
    always_comb begin
        load_use_c  = 1'b0;
        md_hazard_c = 1'b0;
        if (bus.id_valid && ex_q.dst.valid && ex_q.dst.is_load && ex_q.dst.wr_en
            && (ex_q.dst.wr_addr != '0)) begin
            load_use_c = (bus.id_use_rs && (bus.id_rs == ex_q.dst.wr_addr))
                      || (bus.id_use_rt && (bus.id_rt == ex_q.dst.wr_addr));
        end
        if (bus.id_valid && (bus.id_is_md || bus.id_uses_hilo) && md_busy_c) begin
            md_hazard_c = 1'b1;
        end
        stall_c = load_use_c || md_hazard_c;
    end

    // Forwarding selects for the instruction in EX; MEM (newest) wins over WB.
    always_comb begin
        sel_a_c = SEL_RF;
        sel_b_c = SEL_RF;
        if (ex_q.use_rs && (ex_q.rs != '0)) begin
            if (mem_q.valid && mem_q.wr_en && !mem_q.is_load && (mem_q.wr_addr == ex_q.rs)) begin
                sel_a_c = SEL_MEM;
            end else if (wb_q.valid && wb_q.wr_en && (wb_q.wr_addr == ex_q.rs)) begin
                sel_a_c = SEL_WB;
            end
        end
        if (ex_q.use_rt && (ex_q.rt != '0)) begin
            if (mem_q.valid && mem_q.wr_en && !mem_q.is_load && (mem_q.wr_addr == ex_q.rt)) begin
                sel_b_c = SEL_MEM;
            end else if (wb_q.valid && wb_q.wr_en && (wb_q.wr_addr == ex_q.rt)) begin
                sel_b_c = SEL_WB;
            end
        end
    end

    // Next EX record: a real ID instruction, or an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (bus.id_valid && !stall_c) begin
            ex_d.dst.valid   = 1'b1;
            ex_d.dst.wr_en   = bus.id_wr_en;
            ex_d.dst.wr_addr = bus.id_wr_addr;
            ex_d.dst.is_load = bus.id_is_load;
            ex_d.rs          = bus.id_rs;
            ex_d.rt          = bus.id_rt;
            ex_d.use_rs      = bus.id_use_rs;
            ex_d.use_rt      = bus.id_use_rt;
        end
    end

    // Shadow pipeline advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q.dst;
            wb_q  <= mem_q;
        end
    end

    // Mult/div occupancy. The counter reaches 0 on the edge that returns to
    // IDLE, so BUSY covers the MD_CYCLES-1 cycles following the issue cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (bus.id_valid && bus.id_is_md && !stall_c) begin
                        md_state <= MD_BUSY;
                        md_cnt   <= CNT_W'(MD_CYCLES - 1);
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - CNT_W'(1);
                    if (md_cnt == CNT_W'(1)) begin
                        md_state <= MD_IDLE;
                    end
                end
                default: begin
                    md_state <= MD_IDLE;
                    md_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.fwd_a_sel = sel_a_c;
    assign bus.fwd_b_sel = sel_b_c;
    assign bus.stall     = stall_c;
    assign bus.bubble_ex = stall_c;
    assign bus.md_busy   = md_busy_c;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use and
// mult/div stalls, register-0 handling and asynchronous reset mid-mult.
module tb_fwd_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fwd_hazard_if #(.REG_AW(5)) bus ();

    fwd_hazard_ctrl #(.MD_CYCLES(8), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [4:0] wa, input logic ld, input logic md,
                          input logic hl);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_use_rs    = urs;
        bus.id_use_rt    = urt;
        bus.id_wr_en     = we;
        bus.id_wr_addr   = wa;
        bus.id_is_load   = ld;
        bus.id_is_md     = md;
        bus.id_uses_hilo = hl;
        #2;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) begin
            nop();
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        nop();
        checks++; if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", bus.fwd_a_sel); end
        checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b expected 00", bus.fwd_b_sel); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b expected 0", bus.bubble_ex); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b expected 0", bus.md_busy); end
    endtask

    task automatic test_alu_chain();
        flush(4);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0); // add r3,r1,r2
        tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0); // sub r4,r3,r3
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL alu_b2b_stall: got %b expected 0", bus.stall); end
        tick();
        nop();
        checks++; if (bus.fwd_a_sel !== 2'b10) begin errors++; $display("FAIL alu_b2b_a: got %b expected 10", bus.fwd_a_sel); end
        checks++; if (bus.fwd_b_sel !== 2'b10) begin errors++; $display("FAIL alu_b2b_b: got %b expected 10", bus.fwd_b_sel); end

        flush(4);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0); // add r3
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0); // sub r4,r3,r3
        tick();
        nop();
        checks++; if (bus.fwd_a_sel !== 2'b01) begin errors++; $display("FAIL alu_gap_a: got %b expected 01", bus.fwd_a_sel); end
        checks++; if (bus.fwd_b_sel !== 2'b01) begin errors++; $display("FAIL alu_gap_b: got %b expected 01", bus.fwd_b_sel); end
    endtask

    task automatic test_double_producer();
        flush(4);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); // add r5
        tick();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); // add r5
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0); // or r6,r5,r0
        tick();
        nop();
        checks++; if (bus.fwd_a_sel !== 2'b10) begin errors++; $display("FAIL dbl_prod_a: got %b expected 10", bus.fwd_a_sel); end
        checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL dbl_prod_b: got %b expected 00", bus.fwd_b_sel); end
    endtask

    task automatic test_load_use();
        flush(4);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0); // lw r2,0(r1)
        tick();
        set_id(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); // add r7,r2,r1
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ld_use_stall: got %b expected 1", bus.stall); end
        checks++; if (bus.bubble_ex !== 1'b1) begin errors++; $display("FAIL ld_use_bubble: got %b expected 1", bus.bubble_ex); end
        tick();
        set_id(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); // add held in ID
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ld_use_stall_2nd: got %b expected 0", bus.stall); end
        checks++; if (bus.bubble_ex !== 1'b0) begin errors++; $display("FAIL ld_use_bubble_2nd: got %b expected 0", bus.bubble_ex); end
        tick();
        nop();
        checks++; if (bus.fwd_a_sel !== 2'b01) begin errors++; $display("FAIL ld_use_a: got %b expected 01", bus.fwd_a_sel); end
        checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL ld_use_b: got %b expected 00", bus.fwd_b_sel); end

        flush(4);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0); // lw r2
        tick();
        set_id(1'b1, 5'd2, 5'd4, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); // rs=r2 unused
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ld_nouse_stall: got %b expected 0", bus.stall); end
        tick();
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); // independent
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ld_indep_stall: got %b expected 0", bus.stall); end
        tick();
    endtask

    task automatic test_r0();
        flush(4);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); // addi r0,r1
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0); // reader of r0
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_alu_stall: got %b expected 0", bus.stall); end
        tick();
        nop();
        checks++; if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL r0_a: got %b expected 00", bus.fwd_a_sel); end
        checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL r0_b: got %b expected 00", bus.fwd_b_sel); end
        flush(4);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); // lw r0
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_load_stall: got %b expected 0", bus.stall); end
        tick();
    endtask

    task automatic test_md();
        int n;
        flush(10);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); // mult r1,r2
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL md_issue_stall: got %b expected 0", bus.stall); end
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1); // mflo r8
        checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_set: got %b expected 1", bus.md_busy); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.stall !== 1'b1) break;
            n++;
            tick();
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        end
        checks++; if (n != 7) begin errors++; $display("FAIL md_stall_len: got %0d expected 7", n); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL md_busy_clear: got %b expected 0", bus.md_busy); end
        tick();
        nop();

        // mult stalled by load-use must not start the counter until it issues
        flush(4);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0); // lw r2
        tick();
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); // mult r2,r3
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ldmd_stall: got %b expected 1", bus.stall); end
        tick();
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL ldmd_busy_early: got %b expected 0", bus.md_busy); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ldmd_stall_2nd: got %b expected 0", bus.stall); end
        tick();
        nop();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.md_busy !== 1'b1) break;
            n++;
            tick();
        end
        checks++; if (n != 7) begin errors++; $display("FAIL ldmd_busy_len: got %0d expected 7", n); end

        // load-use and MD hazard overlapping: one continuous stall
        flush(4);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); // mult
        tick();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0); // lw r2
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL both_lw_stall: got %b expected 0", bus.stall); end
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); // div r2,r3
            if (bus.stall !== 1'b1) break;
            n++;
            tick();
        end
        checks++; if (n != 6) begin errors++; $display("FAIL both_stall_len: got %0d expected 6", n); end
        tick();
        nop();
        checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL both_div_busy: got %b expected 1", bus.md_busy); end
        checks++; if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL both_div_a: got %b expected 00", bus.fwd_a_sel); end
    endtask

    task automatic test_reset_mid_md();
        flush(10);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); // mult
        tick();
        nop();
        repeat (3) tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1); // mflo
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rst_md_pre_stall: got %b expected 1", bus.stall); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy: got %b expected 0", bus.md_busy); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_md_stall: got %b expected 0", bus.stall); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1); // mflo
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_mflo_stall: got %b expected 0", bus.stall); end
        tick();
        nop();
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL rst_mflo_busy: got %b expected 0", bus.md_busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_alu_chain();
        test_double_producer();
        test_load_use();
        test_r0();
        test_md();
        test_reset_mid_md();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
